// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single valid/ready memory bus.
// One buffered request per port, one transaction in flight, timeout error on a silent bus.
module mem_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_valid,
    input  logic        p0_instr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    output logic        p0_err,
    input  logic        p1_valid,
    input  logic        p1_instr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic        p1_err,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t state, state_next;
    logic        owner;
    logic        last_grant;
    logic [15:0] cnt;

    logic [1:0]       pend;
    logic [1:0]       pend_instr;
    logic [1:0][31:0] pend_addr;
    logic [1:0][31:0] pend_wdata;
    logic [1:0][3:0]  pend_wstrb;

    logic [1:0]       in_valid;
    logic [1:0]       in_instr;
    logic [1:0][31:0] in_addr;
    logic [1:0][31:0] in_wdata;
    logic [1:0][3:0]  in_wstrb;

    logic [1:0]  cand;
    logic [1:0]  capture;
    logic [1:0]  grant_mask;
    logic        grant;
    logic        grant_port;
    logic        done;
    logic        timed_out;
    logic        sel_instr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    assign in_valid = {p1_valid, p0_valid};
    assign in_instr = {p1_instr, p0_instr};
    assign in_addr  = {p1_addr, p0_addr};
    assign in_wdata = {p1_wdata, p0_wdata};
    assign in_wstrb = {p1_wstrb, p0_wstrb};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cand       = '0;
        capture    = '0;
        grant      = 1'b0;
        grant_port = 1'b0;
        grant_mask = '0;
        done       = 1'b0;
        timed_out  = 1'b0;
        if (state == IDLE) begin
            // A fresh strobe competes directly; on a tie the port that did not go last wins.
            cand       = pend | in_valid;
            grant      = |cand;
            grant_port = (cand == 2'b11) ? ~last_grant : cand[1];
            grant_mask = {grant & grant_port, grant & ~grant_port};
            if (grant) begin
                state_next = BUSY;
            end
            capture = in_valid & ~pend & ~grant_mask;
        end else begin
            // A response arriving on the last counted cycle still wins over the timeout.
            done      = mem_ready | (cnt == CNT_LAST);
            timed_out = ~mem_ready & (cnt == CNT_LAST);
            if (done) begin
                state_next = IDLE;
            end
            capture = in_valid & ~pend & ({~owner, owner} | {2{done}});
        end
        sel_instr = pend[grant_port] ? pend_instr[grant_port] : in_instr[grant_port];
        sel_addr  = pend[grant_port] ? pend_addr[grant_port]  : in_addr[grant_port];
        sel_wdata = pend[grant_port] ? pend_wdata[grant_port] : in_wdata[grant_port];
        sel_wstrb = pend[grant_port] ? pend_wstrb[grant_port] : in_wstrb[grant_port];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            pend       <= '0;
            mem_valid  <= 1'b0;
            mem_instr  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            p0_ready   <= 1'b0;
            p0_rdata   <= '0;
            p0_err     <= 1'b0;
            p1_ready   <= 1'b0;
            p1_rdata   <= '0;
            p1_err     <= 1'b0;
        end else begin
            mem_valid <= grant;
            if (grant) begin
                owner     <= grant_port;
                mem_instr <= sel_instr;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_wstrb <= sel_wstrb;
            end
            cnt <= (state == BUSY && !done) ? cnt + 16'd1 : 16'd0;
            if (done) begin
                last_grant <= owner;
            end
            pend     <= (pend | capture) & ~grant_mask;
            p0_ready <= done & ~owner;
            p0_err   <= timed_out & ~owner;
            p0_rdata <= (done & ~owner & mem_ready) ? mem_rdata : 32'd0;
            p1_ready <= done & owner;
            p1_err   <= timed_out & owner;
            p1_rdata <= (done & owner & mem_ready) ? mem_rdata : 32'd0;
        end
    end

    // Buffered request fields only matter while pend is set, so they carry no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (capture[i]) begin
                pend_instr[i] <= in_instr[i];
                pend_addr[i]  <= in_addr[i];
                pend_wdata[i] <= in_wdata[i];
                pend_wstrb[i] <= in_wstrb[i];
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 1'b0, p0_instr = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [3:0]  p0_wstrb = '0;
    logic [31:0] p0_rdata;
    logic        p0_ready, p0_err;
    logic        p1_valid = 1'b0, p1_instr = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p1_wstrb = '0;
    logic [31:0] p1_rdata;
    logic        p1_ready, p1_err;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .p0_valid(p0_valid), .p0_instr(p0_instr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_rdata(p0_rdata), .p0_ready(p0_ready), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_instr(p1_instr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_rdata(p1_rdata), .p1_ready(p1_ready), .p1_err(p1_err),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed-scenario monitor and slave ----------------
    int          lc, ready_at, stray_at, slv_lat;
    logic [31:0] slv_data;
    int          mv_cyc[$];
    logic [31:0] mv_addr[$];
    int          rdy_n[2], rdy_cyc[2];
    logic [31:0] rdy_data[2];
    logic        rdy_err[2];
    logic        in_busy, stable_ok, zero_ok;
    logic        hold_instr;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_wstrb;

    task automatic begin_scn();
        lc = 0; ready_at = -100; stray_at = -100; slv_lat = 1; slv_data = '0;
        mv_cyc.delete(); mv_addr.delete();
        for (int p = 0; p < 2; p++) begin
            rdy_n[p] = 0; rdy_cyc[p] = -1; rdy_data[p] = '0; rdy_err[p] = 1'b0;
        end
        in_busy = 1'b0; stable_ok = 1'b1; zero_ok = 1'b1;
    endtask

    task automatic mon();
        @(negedge clock);
        if (mem_valid) begin
            mv_cyc.push_back(lc);
            mv_addr.push_back(mem_addr);
            hold_instr = mem_instr; hold_addr = mem_addr;
            hold_wdata = mem_wdata; hold_wstrb = mem_wstrb;
            in_busy = 1'b1;
            ready_at = (slv_lat < 0) ? -100 : lc + slv_lat;
        end else if (in_busy) begin
            if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !==
                {hold_instr, hold_addr, hold_wdata, hold_wstrb}) stable_ok = 1'b0;
        end
        if (p0_ready) begin
            rdy_n[0]++; rdy_cyc[0] = lc; rdy_data[0] = p0_rdata; rdy_err[0] = p0_err; in_busy = 1'b0;
        end else if (p0_rdata != 0 || p0_err) zero_ok = 1'b0;
        if (p1_ready) begin
            rdy_n[1]++; rdy_cyc[1] = lc; rdy_data[1] = p1_rdata; rdy_err[1] = p1_err; in_busy = 1'b0;
        end else if (p1_rdata != 0 || p1_err) zero_ok = 1'b0;
        mem_ready = (lc == ready_at) || (lc == stray_at);
        mem_rdata = mem_ready ? slv_data : 32'hBAD0BAD0;
        lc++;
    endtask

    task automatic step();
        mon();
        @(posedge clock);
        #1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    task automatic drive_port(input int p, input logic instr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
        if (p == 0) begin
            p0_valid = 1'b1; p0_instr = instr; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
        end else begin
            p1_valid = 1'b1; p1_instr = instr; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_mem_instr"}, mem_instr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
        chk({tag, "_p0_ready"}, p0_ready, 0);
        chk({tag, "_p0_rdata"}, p0_rdata, 0);
        chk({tag, "_p0_err"}, p0_err, 0);
        chk({tag, "_p1_ready"}, p1_ready, 0);
        chk({tag, "_p1_rdata"}, p1_rdata, 0);
        chk({tag, "_p1_err"}, p1_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          port;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;       // slave cycles after mem_valid, -1 = never responds
        int          stray;     // cycle of an unsolicited mem_ready, -100 = none
        logic [31:0] sdata;
        int          exp_off;   // cycle of pX_ready relative to the strobe
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    // ---------------- random-phase model state ----------------
    logic        r_wait[2], r_free[2], r_err[2], r_instr[2];
    int          r_wcyc[2], r_resp[2];
    logic [31:0] r_rdata[2], r_addr[2], r_wdata[2];
    logic [3:0]  r_wstrb[2];
    int          r_bus_free, r_ready_at, r_last, r_own, r_lat, r_g;
    logic [31:0] r_sdata;
    logic        c0, c1, exp_mv, got_rdy;

    initial begin
        vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 1,  -100, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_2004, 32'h0,         4'h0, 0,  -100, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{0, 1'b0, 32'h0000_3000, 32'h1234_5678, 4'hF, 4,  -100, 32'h1111_0000, 6, 32'h1111_0000, 1'b0};
        vecs[3] = '{0, 1'b0, 32'h0000_4000, 32'h0,         4'h0, -1, 12,   32'h7777_7777, 9, 32'h0,         1'b1};
        vecs[4] = '{1, 1'b0, 32'h0000_5008, 32'h0,         4'h0, 7,  -100, 32'h55AA_55AA, 9, 32'h55AA_55AA, 1'b0};
        vecs[5] = '{1, 1'b1, 32'h0000_6000, 32'hA5A5_A5A5, 4'h3, -1, -100, 32'h0,         9, 32'h0,         1'b1};
        vecs[6] = '{0, 1'b1, 32'h0000_7004, 32'h0,         4'h0, 6,  -100, 32'h0F0F_0F0F, 8, 32'h0F0F_0F0F, 1'b0};

        do_reset();

        // Simultaneous strobes twice: port 0 first both times, since port 1 finishes each round.
        for (int rep = 0; rep < 2; rep++) begin
            begin_scn(); slv_data = 32'hA5A5_0001;
            drive_port(0, 1'b0, 32'h100, 32'h0, 4'h0);
            drive_port(1, 1'b0, 32'h200, 32'h0, 4'h0);
            step();
            repeat (10) step();
            chk("tie_count", mv_addr.size(), 2);
            if (mv_addr.size() == 2) begin
                chk("tie_first", mv_addr[0], 32'h100);
                chk("tie_second", mv_addr[1], 32'h200);
                chk("tie_spacing", mv_cyc[1], 4);
            end
            chk("tie_p0_readies", rdy_n[0], 1);
            chk("tie_p1_readies", rdy_n[1], 1);
            chk("tie_p0_cycle", rdy_cyc[0], 3);
            chk("tie_p1_cycle", rdy_cyc[1], 6);
            chk("tie_zero_idle", zero_ok, 1);
        end

        for (int i = 0; i < 7; i++) begin
            begin_scn();
            slv_lat = vecs[i].lat; stray_at = vecs[i].stray; slv_data = vecs[i].sdata;
            drive_port(vecs[i].port, vecs[i].instr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            step();
            repeat (14) step();
            chk($sformatf("vec%0d_mv_count", i), mv_cyc.size(), 1);
            if (mv_cyc.size() > 0) begin
                chk($sformatf("vec%0d_mv_cycle", i), mv_cyc[0], 1);
                chk($sformatf("vec%0d_addr", i), mv_addr[0], vecs[i].addr);
            end
            chk($sformatf("vec%0d_wdata", i), hold_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_wstrb", i), hold_wstrb, vecs[i].wstrb);
            chk($sformatf("vec%0d_instr", i), hold_instr, vecs[i].instr);
            chk($sformatf("vec%0d_stable", i), stable_ok, 1);
            chk($sformatf("vec%0d_own_readies", i), rdy_n[vecs[i].port], 1);
            chk($sformatf("vec%0d_other_readies", i), rdy_n[1 - vecs[i].port], 0);
            chk($sformatf("vec%0d_ready_cycle", i), rdy_cyc[vecs[i].port], vecs[i].exp_off);
            chk($sformatf("vec%0d_rdata", i), rdy_data[vecs[i].port], vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), rdy_err[vecs[i].port], vecs[i].exp_err);
            chk($sformatf("vec%0d_zero_idle", i), zero_ok, 1);
        end

        // Port 1 keeps re-requesting; port 0's buffered request must go next.
        begin_scn(); slv_data = 32'h0000_B0B0;
        drive_port(1, 1'b0, 32'h2000, 32'h0, 4'h0); step();
        drive_port(0, 1'b0, 32'h0B00, 32'h0, 4'h0); step();
        step();
        drive_port(1, 1'b0, 32'h2010, 32'h0, 4'h0); step();
        repeat (10) step();
        chk("starve_count", mv_addr.size(), 3);
        if (mv_addr.size() == 3) begin
            chk("starve_p0_second", mv_addr[1], 32'h0B00);
            chk("starve_p0_cycle", mv_cyc[1], 4);
            chk("starve_p1_third", mv_addr[2], 32'h2010);
        end
        chk("starve_p0_readies", rdy_n[0], 1);
        chk("starve_p1_readies", rdy_n[1], 2);

        // Owner strobe mid-transaction is dropped; one in its completion cycle is kept.
        begin_scn(); slv_data = 32'h0000_0C0C;
        drive_port(0, 1'b0, 32'h400, 32'h0, 4'h0); step();
        drive_port(0, 1'b0, 32'h4DD, 32'h0, 4'h0); step();
        drive_port(0, 1'b0, 32'h408, 32'h0, 4'h0); step();
        repeat (10) step();
        chk("owner_count", mv_addr.size(), 2);
        if (mv_addr.size() == 2) begin
            chk("owner_second_addr", mv_addr[1], 32'h408);
            chk("owner_second_cycle", mv_cyc[1], 4);
        end
        chk("owner_readies", rdy_n[0], 2);

        // Reset in the second BUSY cycle aborts the request silently.
        begin_scn(); slv_lat = -1;
        drive_port(0, 1'b0, 32'h500, 32'h0, 4'h0); step();
        step();
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        begin_scn(); slv_lat = 2; slv_data = 32'h600D_DA7A;
        drive_port(1, 1'b0, 32'h600, 32'h0, 4'h0); step();
        repeat (12) step();
        chk("postreset_p0_readies", rdy_n[0], 0);
        chk("postreset_p1_readies", rdy_n[1], 1);
        chk("postreset_p1_cycle", rdy_cyc[1], 4);
        chk("postreset_p1_rdata", rdy_data[1], 32'h600D_DA7A);
        chk("postreset_mv_count", mv_addr.size(), 1);

        // ---------------- randomized run against the transaction model ----------------
        do_reset();
        for (int p = 0; p < 2; p++) begin
            r_wait[p] = 1'b0; r_free[p] = 1'b1; r_resp[p] = -1; r_wcyc[p] = 0;
        end
        r_bus_free = 0; r_ready_at = -100; r_last = 1; r_own = 0; r_sdata = '0;
        for (int k = 0; k < 700; k++) begin
            p0_valid = 1'b0;
            p1_valid = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (k < 670 && r_free[p] && $urandom_range(0, 3) != 0) begin
                    r_free[p] = 1'b0; r_wait[p] = 1'b1; r_wcyc[p] = k;
                    r_instr[p] = 1'($urandom_range(0, 1));
                    r_addr[p] = $urandom; r_wdata[p] = $urandom;
                    r_wstrb[p] = 4'($urandom_range(0, 15));
                    drive_port(p, r_instr[p], r_addr[p], r_wdata[p], r_wstrb[p]);
                end
            end
            @(negedge clock);
            for (int p = 0; p < 2; p++) begin
                got_rdy = (p == 0) ? p0_ready : p1_ready;
                chk($sformatf("rnd_p%0d_ready_c%0d", p, k), got_rdy, (r_resp[p] == k));
                if (r_resp[p] == k) begin
                    chk($sformatf("rnd_p%0d_rdata_c%0d", p, k), (p == 0) ? p0_rdata : p1_rdata, r_rdata[p]);
                    chk($sformatf("rnd_p%0d_err_c%0d", p, k), (p == 0) ? p0_err : p1_err, r_err[p]);
                    r_free[p] = 1'b1;
                    r_resp[p] = -1;
                end
            end
            c0 = r_wait[0] && (r_wcyc[0] < k);
            c1 = r_wait[1] && (r_wcyc[1] < k);
            exp_mv = (k - 1 >= r_bus_free) && (c0 || c1);
            chk($sformatf("rnd_mem_valid_c%0d", k), mem_valid, exp_mv);
            if (exp_mv) begin
                r_g = (c0 && c1) ? 1 - r_last : (c1 ? 1 : 0);
                chk($sformatf("rnd_addr_c%0d", k), mem_addr, r_addr[r_g]);
                chk($sformatf("rnd_wdata_c%0d", k), mem_wdata, r_wdata[r_g]);
                chk($sformatf("rnd_wstrb_c%0d", k), mem_wstrb, r_wstrb[r_g]);
                chk($sformatf("rnd_instr_c%0d", k), mem_instr, r_instr[r_g]);
                r_wait[r_g] = 1'b0; r_own = r_g; r_last = r_g;
                r_lat = $urandom_range(0, 8);
                if (r_lat == 8) begin
                    r_resp[r_g] = k + TO; r_rdata[r_g] = '0; r_err[r_g] = 1'b1; r_ready_at = -100;
                end else begin
                    r_sdata = $urandom;
                    r_resp[r_g] = k + r_lat + 1; r_rdata[r_g] = r_sdata; r_err[r_g] = 1'b0;
                    r_ready_at = k + r_lat;
                end
                r_bus_free = r_resp[r_g];
            end else if (k < r_bus_free) begin
                chk($sformatf("rnd_hold_addr_c%0d", k), mem_addr, r_addr[r_own]);
                chk($sformatf("rnd_hold_wdata_c%0d", k), mem_wdata, r_wdata[r_own]);
                chk($sformatf("rnd_hold_wstrb_c%0d", k), mem_wstrb, r_wstrb[r_own]);
            end
            mem_ready = (k == r_ready_at);
            mem_rdata = mem_ready ? r_sdata : $urandom;
            @(posedge clock);
            #1;
        end
        chk("rnd_all_returned_p0", r_free[0], 1);
        chk("rnd_all_returned_p1", r_free[1], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single CPU-side memory bus (valid/instr/addr/wdata/wstrb → rdata/ready) between two requesters, e.g. the core and a DMA/debug master. It sits in front of the SoC address decoder. It buffers one request per port, issues one transaction at a time downstream, and returns the response to the owning port. A timeout returns an error when the bus does not respond, which covers unmapped addresses that never raise ready.

## Interface
- TIMEOUT, 1024, maximum cycles spent waiting for mem_ready before forced completion (legal 2..65535)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- p0_valid / p1_valid  in  1  one-cycle request strobe per port
- p0_instr / p1_instr  in  1  fetch qualifier
- p0_addr / p1_addr  in  32  byte address
- p0_wdata / p1_wdata  in  32  write data
- p0_wstrb / p1_wstrb  in  4  byte strobes; 0 = read
- p0_rdata / p1_rdata  out  32  response data, valid with ready
- p0_ready / p1_ready  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  timeout flag, valid with ready
- mem_valid  out  1  one-cycle request pulse to decoder
- mem_instr, mem_addr[32], mem_wdata[32], mem_wstrb[4]  out  request fields, held stable while BUSY
- mem_rdata  in  32  response data
- mem_ready  in  1  response strobe

## Operation
- Per-port pending register: holds one entry with instr, addr, wdata, wstrb and a pend flag.
  - A pX_valid is captured when the port has no pend and no in-flight transaction, or when that port's transaction completes in the same cycle.
  - Otherwise the strobe is dropped. This is a requester protocol violation.
- FSM states: IDLE, BUSY.
- IDLE:
  - Candidates are pend entries plus same-cycle pX_valid strobes. An incoming strobe bypasses the buffer.
  - One candidate → grant it. Two candidates → grant the port ≠ last_grant.
  - On grant: register the owner, latch the fields onto mem_*, set mem_valid=1 for the next cycle, clear the owner's pend, go to BUSY.
  - The losing strobe is stored in its pend register.
- BUSY:
  - mem_valid is 1 only in the first BUSY cycle. Fields stay stable throughout.
  - cnt starts at 0 and increments each BUSY cycle without mem_ready.
  - mem_ready=1 (including the first BUSY cycle) → next cycle the owner gets ready=1, rdata=mem_rdata, err=0. last_grant←owner, go to IDLE.
  - cnt==TIMEOUT-1 and mem_ready=0 → next cycle the owner gets ready=1, rdata=0, err=1. last_grant←owner, go to IDLE.
  - mem_ready and timeout in the same cycle → normal completion, err=0.
- mem_ready in IDLE (late response after a timeout) is ignored.
- The non-owner port's ready stays 0. Its new strobes are captured into its pend register if that is free.
- Reset values:
  - State IDLE, pend=0, cnt=0, last_grant=1 (port 0 wins first tie).
  - mem_valid=0, mem_addr/wdata=0, mem_wstrb=0, mem_instr=0.
  - All pX_ready=0, pX_rdata=0, pX_err=0.
- Reset mid-transaction aborts it. No response is ever delivered for the aborted request.

## Timing
- Latency: pX_valid in cycle t (bus idle) → mem_valid in t+1 → mem_ready in t+1+L → pX_ready in t+2+L.
  - For a 1-cycle slave (L=1), pX_ready is at t+3.
- Completion → IDLE next cycle → next mem_valid the cycle after. Minimum spacing of mem_valid pulses is L+2 cycles.
- Timeout response: pX_ready at cycle t+1+TIMEOUT, with mem_valid in t+1.
- pX_ready, pX_rdata and pX_err are registered, single-cycle, and return to 0 in the following cycle.

## Test plan
- Single port-0 read, slave ready one cycle after mem_valid, mem_rdata=0xDEADBEEF, valid at cycle 0 → mem_valid at 1, p0_ready at 3 with p0_rdata=0xDEADBEEF, p0_err=0.
- Both ports strobe in the same cycle after reset (addrs 0x100, 0x200) → first issued mem_addr=0x100, then 0x200. Repeat the simultaneous strobes → order is 0x100 then 0x200 again (alternation). Each port gets exactly one ready.
- Port 1 held continuously busy with requests while port 0 issues one request → port 0 is granted within one transaction (no starvation).
- TIMEOUT=8, mem_ready never asserted → p0_ready at cycle 9 with p0_rdata=0, p0_err=1. A stray mem_ready at cycle 12 produces no pX_ready.
- Write 0x12345678 with wstrb=0xF → mem_wdata and mem_wstrb stay stable throughout BUSY. When a strobe arrives during BUSY (port idle), it issues right after completion.
- Reset asserted in the second BUSY cycle → all outputs 0 immediately. After release, no pX_ready for the aborted request, and a fresh p1 request completes normally.
